// File: rtl/myfilter_pkg.sv
// Shared types and default sizes for the filter configuration I2C front end.
package myfilter_pkg;

    // Register-bank request controller states.
    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WREQ = 2'd1,
        C_RREQ = 2'd2
    } i2c_frame_ctrl_t;

    // Data bytes per frame, pointer byte included.
    localparam int MYFILTER_FRAME_BYTES = 4;
    // Number of addressable filter registers (power of two).
    localparam int MYFILTER_REG_COUNT   = 16;

endpackage

// File: rtl/i2c_bitcnt.sv
// Bit counter for the I2C byte currently on the wire, the registered
// byte-complete flag and the rising-edge detector for the FSM clear level.
module i2c_bitcnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_in,
    input  logic       next_in,
    output logic [3:0] bitcnt_out,
    output logic       byteok_out,
    output logic       clr_rise_out
);

    logic [3:0] r_bitcnt;
    logic [3:0] w_bitcnt_next;
    logic       r_byteok;
    logic       r_clr_q;

    // Next bit count: clear wins over advance, advance saturates at 8.
    always_comb begin
        w_bitcnt_next = r_bitcnt;
        if (clr_in) begin
            w_bitcnt_next = 4'd0;
        end else if (next_in && (r_bitcnt != 4'd8)) begin
            w_bitcnt_next = r_bitcnt + 4'd1;
        end
    end

    // Counter, byte-complete flag (tracks the new count) and clear history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitcnt <= 4'd0;
            r_byteok <= 1'b0;
            r_clr_q  <= 1'b0;
        end else begin
            r_bitcnt <= w_bitcnt_next;
            r_byteok <= (w_bitcnt_next == 4'd8);
            r_clr_q  <= clr_in;
        end
    end

    assign bitcnt_out   = r_bitcnt;
    assign byteok_out   = r_byteok;
    assign clr_rise_out = clr_in & ~r_clr_q;

endmodule

// File: rtl/i2c_frame_ctrl.sv
// Frame sequencer and register-bank requester between the I2C slave FSM and
// the filter configuration register bank. Counts bytes in a frame, keeps the
// register pointer and issues one-outstanding write/read requests.
// Optional feature: define MYFILTER_AUTOINC_EN to advance the register
// pointer after every acknowledged access; otherwise the pointer only changes
// when an upload frame delivers its pointer byte.
module i2c_frame_ctrl
    import myfilter_pkg::*;
#(
    parameter int FRAME_BYTES = MYFILTER_FRAME_BYTES,
    parameter int REG_COUNT   = MYFILTER_REG_COUNT,
    parameter int ADDR_W      = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_in,
    input  logic              next_in,
    input  logic              byteen_in,
    input  logic              ul_in,
    input  logic              dl_in,
    input  logic [7:0]        rx_byte_in,
    output logic [3:0]        bitcnt_out,
    output logic              byteok_out,
    output logic              frameok_out,
    output logic [ADDR_W-1:0] reg_addr_out,
    output logic              wr_req_out,
    output logic              rd_req_out,
    output logic [7:0]        wdata_out,
    input  logic              reg_ack_in,
    input  logic [7:0]        rdata_in,
    output logic [7:0]        tx_byte_out,
    output logic              err_out
);

    localparam logic [3:0] FRAME_LAST = 4'(FRAME_BYTES);

    i2c_frame_ctrl_t   r_state;
    i2c_frame_ctrl_t   w_state_next;
    logic [3:0]        r_bytecnt;
    logic              r_dl_q;
    logic              r_err;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_tx;

    logic w_clr_rise;
    logic w_byte_done;
    logic w_frameok;
    logic w_dl_rise;
    logic w_ld_ptr;
    logic w_wr_need;
    logic w_rd_need;
    logic w_busy;
    logic w_ack;
    logic w_free;
    logic w_wr_issue;
    logic w_drop;
    logic w_wr_req;
    logic w_rd_req;

    i2c_bitcnt u_bitcnt (
        .clk          (clk),
        .rst          (rst),
        .clr_in       (clr_in),
        .next_in      (next_in),
        .bitcnt_out   (bitcnt_out),
        .byteok_out   (byteok_out),
        .clr_rise_out (w_clr_rise)
    );

    // A clear rising during the data phase closes one data byte.
    assign w_byte_done = w_clr_rise & byteen_in;
    assign w_frameok   = (r_bytecnt == FRAME_LAST);
    assign w_dl_rise   = dl_in & ~r_dl_q;

    // Upload: byte 0 is the register pointer, later bytes are write data.
    // Upload takes precedence if the FSM ever flags both directions.
    assign w_ld_ptr  = w_byte_done & ul_in & (r_bytecnt == 4'd0);
    assign w_wr_need = w_byte_done & ul_in & (r_bytecnt != 4'd0);
    // Download: prefetch at frame start, then one per byte until frame end.
    assign w_rd_need = ~ul_in & dl_in & (w_dl_rise | (w_byte_done & ~w_frameok));

    // The controller can take new work when idle, or when the pending
    // request is being acknowledged in this very cycle.
    assign w_busy     = (r_state != C_IDLE);
    assign w_ack      = w_busy & reg_ack_in;
    assign w_free     = ~w_busy | reg_ack_in;
    assign w_wr_issue = w_wr_need & w_free;
    assign w_drop     = (w_wr_need | w_rd_need) & ~w_free;

    // Request FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and request outputs; a request is held until acknowledged.
    always_comb begin
        w_state_next = r_state;
        w_wr_req     = 1'b0;
        w_rd_req     = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (w_wr_need) begin
                    w_state_next = C_WREQ;
                end else if (w_rd_need) begin
                    w_state_next = C_RREQ;
                end
            end
            C_WREQ: begin
                w_wr_req = 1'b1;
                if (reg_ack_in) begin
                    if (w_wr_need) begin
                        w_state_next = C_WREQ;
                    end else if (w_rd_need) begin
                        w_state_next = C_RREQ;
                    end else begin
                        w_state_next = C_IDLE;
                    end
                end
            end
            C_RREQ: begin
                w_rd_req = 1'b1;
                if (reg_ack_in) begin
                    if (w_wr_need) begin
                        w_state_next = C_WREQ;
                    end else if (w_rd_need) begin
                        w_state_next = C_RREQ;
                    end else begin
                        w_state_next = C_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = C_IDLE;
            end
        endcase
    end

    // Data-byte counter: runs only during the data phase, saturates at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bytecnt <= 4'd0;
        end else if (!byteen_in) begin
            r_bytecnt <= 4'd0;
        end else if (w_byte_done && !w_frameok) begin
            r_bytecnt <= r_bytecnt + 4'd1;
        end
    end

    // Register pointer. A pointer byte arriving while a request is still
    // outstanding is ignored so the address stays stable under the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_ld_ptr && w_free) begin
            r_ptr <= rx_byte_in[ADDR_W-1:0];
        end
`ifdef MYFILTER_AUTOINC_EN
        else if (w_ack) begin
            r_ptr <= r_ptr + ADDR_W'(1);
        end
`endif
    end

    // Write data latch, read data capture, dl edge history and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdata <= 8'd0;
            r_tx    <= 8'd0;
            r_dl_q  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_dl_q <= dl_in;
            if (w_wr_issue) begin
                r_wdata <= rx_byte_in;
            end
            if ((r_state == C_RREQ) && reg_ack_in) begin
                r_tx <= rdata_in;
            end
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    assign frameok_out  = w_frameok;
    assign reg_addr_out = r_ptr;
    assign wr_req_out   = w_wr_req;
    assign rd_req_out   = w_rd_req;
    assign wdata_out    = r_wdata;
    assign tx_byte_out  = r_tx;
    assign err_out      = r_err;

endmodule

// File: tb/tb_i2c_frame_ctrl.sv
// Self-checking bench for i2c_frame_ctrl: directed frames plus randomized
// upload/download frames checked against a transaction-level model.
module tb_i2c_frame_ctrl;
    import myfilter_pkg::*;

    localparam int FB = MYFILTER_FRAME_BYTES;
    localparam int RC = MYFILTER_REG_COUNT;
    localparam int AW = $clog2(RC);
`ifdef MYFILTER_AUTOINC_EN
    localparam int INC = 1;
`else
    localparam int INC = 0;
`endif

    logic          clk;
    logic          rst;
    logic          clr_in;
    logic          next_in;
    logic          byteen_in;
    logic          ul_in;
    logic          dl_in;
    logic [7:0]    rx_byte_in;
    logic [3:0]    bitcnt_out;
    logic          byteok_out;
    logic          frameok_out;
    logic [AW-1:0] reg_addr_out;
    logic          wr_req_out;
    logic          rd_req_out;
    logic [7:0]    wdata_out;
    logic          reg_ack_in;
    logic [7:0]    rdata_in;
    logic [7:0]    tx_byte_out;
    logic          err_out;

    i2c_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .clr_in       (clr_in),
        .next_in      (next_in),
        .byteen_in    (byteen_in),
        .ul_in        (ul_in),
        .dl_in        (dl_in),
        .rx_byte_in   (rx_byte_in),
        .bitcnt_out   (bitcnt_out),
        .byteok_out   (byteok_out),
        .frameok_out  (frameok_out),
        .reg_addr_out (reg_addr_out),
        .wr_req_out   (wr_req_out),
        .rd_req_out   (rd_req_out),
        .wdata_out    (wdata_out),
        .reg_ack_in   (reg_ack_in),
        .rdata_in     (rdata_in),
        .tx_byte_out  (tx_byte_out),
        .err_out      (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- register bank emulator ----------------
    logic [7:0] bank_mem [RC];
    int  ack_delay  = 2;
    bit  bank_en    = 1'b1;
    int  wait_cnt   = 0;
    bit  tx_pending = 1'b0;
    int  obs_wr_addr[$];
    int  obs_wr_data[$];
    int  obs_rd_addr[$];
    int  obs_tx[$];

    initial begin
        reg_ack_in = 1'b0;
        rdata_in   = 8'd0;
        for (int a = 0; a < RC; a++) bank_mem[a] = 8'(a + 16);
        forever begin
            @(negedge clk);
            if (tx_pending) begin
                obs_tx.push_back(int'(tx_byte_out));
                tx_pending = 1'b0;
            end
            reg_ack_in = 1'b0;
            if (bank_en && (wr_req_out || rd_req_out)) begin
                if (wait_cnt >= ack_delay) begin
                    reg_ack_in = 1'b1;
                    wait_cnt   = 0;
                    if (wr_req_out) begin
                        bank_mem[reg_addr_out] = wdata_out;
                        obs_wr_addr.push_back(int'(reg_addr_out));
                        obs_wr_data.push_back(int'(wdata_out));
                        $display("[TB] WR addr=%0d data=%02h", reg_addr_out, wdata_out);
                    end else begin
                        rdata_in = bank_mem[reg_addr_out];
                        obs_rd_addr.push_back(int'(reg_addr_out));
                        tx_pending = 1'b1;
                        $display("[TB] RD addr=%0d data=%02h", reg_addr_out, bank_mem[reg_addr_out]);
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] model_mem [RC];
    int model_ptr = 0;
    int exp_wr_addr[$];
    int exp_wr_data[$];
    int exp_rd_addr[$];
    int exp_tx[$];
    logic [7:0] fbuf[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_wr_addr.delete(); obs_wr_data.delete();
        obs_rd_addr.delete(); obs_tx.delete();
        exp_wr_addr.delete(); exp_wr_data.delete();
        exp_rd_addr.delete(); exp_tx.delete();
    endtask

    // One data byte: clear low, 8 bit strobes, then clear rises to close it.
    task automatic send_byte(input logic [7:0] b, input int idx);
        @(negedge clk);
        clr_in     = 1'b0;
        rx_byte_in = b;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); next_in = 1'b1;
            @(negedge clk); next_in = 1'b0;
        end
        check("byte_bitcnt", bitcnt_out, 8);
        check("byte_byteok", byteok_out, 1);
        @(negedge clk);
        clr_in = 1'b1;
        @(negedge clk);
        check("frameok", frameok_out, (idx + 1 >= FB) ? 1 : 0);
        check("bitcnt_clr", bitcnt_out, 0);
        tick(6);
    endtask

    task automatic compare_frame(input string name);
        int n;
        check({name, "_wr_count"}, obs_wr_addr.size(), exp_wr_addr.size());
        n = (obs_wr_addr.size() < exp_wr_addr.size()) ? obs_wr_addr.size() : exp_wr_addr.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_wr_addr"}, obs_wr_addr[i], exp_wr_addr[i]);
            check({name, "_wr_data"}, obs_wr_data[i], exp_wr_data[i]);
        end
        check({name, "_rd_count"}, obs_rd_addr.size(), exp_rd_addr.size());
        n = (obs_rd_addr.size() < exp_rd_addr.size()) ? obs_rd_addr.size() : exp_rd_addr.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_rd_addr"}, obs_rd_addr[i], exp_rd_addr[i]);
        end
        n = (obs_tx.size() < exp_tx.size()) ? obs_tx.size() : exp_tx.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_tx"}, obs_tx[i], exp_tx[i]);
        end
        check({name, "_ptr"}, reg_addr_out, model_ptr);
        check({name, "_err"}, err_out, 0);
        check({name, "_frameok_end"}, frameok_out, 0);
        clear_obs();
    endtask

    task automatic upload_frame(input string name);
        @(negedge clk);
        ul_in     = 1'b1;
        byteen_in = 1'b1;
        for (int i = 0; i < fbuf.size(); i++) begin
            if (i == 0) begin
                model_ptr = int'(fbuf[0]) % RC;
            end else begin
                exp_wr_addr.push_back(model_ptr);
                exp_wr_data.push_back(int'(fbuf[i]));
                model_mem[model_ptr] = fbuf[i];
                model_ptr = (model_ptr + INC) % RC;
            end
            send_byte(fbuf[i], i);
        end
        @(negedge clk);
        ul_in     = 1'b0;
        byteen_in = 1'b0;
        tick(4);
        compare_frame(name);
    endtask

    task automatic download_frame(input string name, input int k);
        int nrd;
        nrd = 1 + ((k < FB) ? k : FB);
        for (int j = 0; j < nrd; j++) begin
            exp_rd_addr.push_back(model_ptr);
            exp_tx.push_back(int'(model_mem[model_ptr]));
            model_ptr = (model_ptr + INC) % RC;
        end
        @(negedge clk);
        dl_in     = 1'b1;
        byteen_in = 1'b1;
        tick(6);
        for (int i = 0; i < k; i++) send_byte(8'($urandom_range(0, 255)), i);
        @(negedge clk);
        dl_in     = 1'b0;
        byteen_in = 1'b0;
        tick(4);
        compare_frame(name);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < RC; a++) model_mem[a] = 8'(a + 16);
        rst = 1'b1; clr_in = 1'b1; next_in = 1'b0; byteen_in = 1'b0;
        ul_in = 1'b0; dl_in = 1'b0; rx_byte_in = 8'd0;
        tick(3);
        check("rst_bitcnt", bitcnt_out, 0);
        check("rst_byteok", byteok_out, 0);
        check("rst_frameok", frameok_out, 0);
        check("rst_addr", reg_addr_out, 0);
        check("rst_wr_req", wr_req_out, 0);
        check("rst_rd_req", rd_req_out, 0);
        check("rst_wdata", wdata_out, 0);
        check("rst_tx", tx_byte_out, 0);
        check("rst_err", err_out, 0);
        rst = 1'b0;
        tick(2);

        // Bit counter: 8 strobes, saturation, clear priority.
        clr_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); next_in = 1'b1;
            @(negedge clk); next_in = 1'b0;
        end
        check("bc_seven", bitcnt_out, 7);
        check("bc_byteok_early", byteok_out, 0);
        next_in = 1'b1;
        @(negedge clk); next_in = 1'b0;
        check("bc_eight", bitcnt_out, 8);
        check("bc_byteok", byteok_out, 1);
        next_in = 1'b1;
        @(negedge clk); next_in = 1'b0;
        check("bc_saturate", bitcnt_out, 8);
        clr_in = 1'b1; next_in = 1'b1;
        @(negedge clk); next_in = 1'b0;
        check("bc_clr_prio", bitcnt_out, 0);
        check("bc_byteok_clr", byteok_out, 0);
        tick(2);
        $display("[TB] bit counter checks done");

        // Directed upload and download.
        ack_delay = 2;
        fbuf = {8'h05, 8'hA1, 8'hB2, 8'hC3};
        upload_frame("upload");
        download_frame("download", 1);
        $display("[TB] directed upload/download done, ptr=%0d", reg_addr_out);

        // Pointer wrap.
        fbuf = {8'h0F, 8'h3C, 8'h4D};
        upload_frame("wrap");

        // Randomized frames.
        for (int it = 0; it < 24; it++) begin
            ack_delay = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                int n;
                n = $urandom_range(1, 6);
                fbuf.delete();
                for (int i = 0; i < n; i++) fbuf.push_back(8'($urandom_range(0, 255)));
                upload_frame("rnd_up");
            end else begin
                download_frame("rnd_dn", $urandom_range(0, 6));
            end
        end

        // Overlap: withhold acknowledge across two completed data bytes.
        bank_en = 1'b0;
        clear_obs();
        @(negedge clk);
        ul_in = 1'b1; byteen_in = 1'b1;
        send_byte(8'h03, 0);
        send_byte(8'h5A, 1);
        check("ovl_req", wr_req_out, 1);
        check("ovl_err_before", err_out, 0);
        send_byte(8'h6B, 2);
        check("ovl_err", err_out, 1);
        check("ovl_wdata_held", wdata_out, 8'h5A);
        check("ovl_addr_held", reg_addr_out, 3);
        bank_en = 1'b1;
        tick(6);
        check("ovl_req_done", wr_req_out, 0);
        check("ovl_wr_count", obs_wr_addr.size(), 1);
        if (obs_wr_addr.size() > 0) begin
            check("ovl_wr_addr", obs_wr_addr[0], 3);
            check("ovl_wr_data", obs_wr_data[0], 8'h5A);
        end
        check("ovl_err_sticky", err_out, 1);
        @(negedge clk);
        ul_in = 1'b0; byteen_in = 1'b0;
        tick(3);

        // Reset in the middle of a pending write.
        bank_en = 1'b0;
        clear_obs();
        @(negedge clk);
        ul_in = 1'b1; byteen_in = 1'b1;
        send_byte(8'h09, 0);
        send_byte(8'h77, 1);
        check("rstw_req", wr_req_out, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_wr_req", wr_req_out, 0);
        check("rstw_addr", reg_addr_out, 0);
        check("rstw_err", err_out, 0);
        check("rstw_wdata", wdata_out, 0);
        rst = 1'b0;
        ul_in = 1'b0; byteen_in = 1'b0;
        model_ptr = 0;
        bank_en = 1'b1;
        tick(4);
        check("rstw_idle", wr_req_out, 0);
        check("rstw_no_write", obs_wr_addr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
